// File: rtl/iot_riscv_trap_ctrl.sv
// Machine-mode trap/return sequencer: qualifies EX exceptions, interrupts and MRET,
// sequences the mepc save and a handshaked PC redirect, and owns mcause/MIE/MPIE.
module iot_riscv_trap_ctrl #(
  parameter int unsigned pc_size_p = 32
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_i,
  input  logic                 ex_valid_i,
  input  logic [pc_size_p-1:0] ex_pc_i,
  input  logic                 ex_illegal_i,
  input  logic                 ex_ebreak_i,
  input  logic                 ex_ecall_i,
  input  logic                 ex_mret_i,
  input  logic                 irq_ext_i,
  input  logic                 mie_we_i,
  input  logic                 mie_wdata_i,
  input  logic [31:0]          mtvec_i,
  input  logic [31:0]          mepc_i,
  output logic                 mepc_we_o,
  output logic [31:0]          mepc_wdata_o,
  output logic [31:0]          mcause_o,
  output logic                 mstatus_mie_o,
  output logic                 mstatus_mpie_o,
  output logic                 flush_o,
  output logic                 busy_o,
  output logic                 redir_valid_o,
  output logic [pc_size_p-1:0] redir_pc_o,
  input  logic                 redir_ready_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAVE  = 2'd1,
    REDIR = 2'd2
  } state_e;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;

  state_e               state_q, state_d;
  logic [31:0]          mcause_q;
  logic [31:0]          saved_pc_q;
  logic                 mie_q, mpie_q;
  logic [pc_size_p-1:0] redir_pc_q;

  logic                 take_trap, take_mret;
  logic [31:0]          trap_cause;
  logic [31:0]          ex_pc_ext;
  logic [31:0]          vec_base;
  logic [31:0]          trap_target;
  logic [pc_size_p-1:0] mret_target;
  logic                 unused_bits;

  assign ex_pc_ext   = 32'(ex_pc_i);
  assign vec_base    = {mtvec_i[31:2], 2'b00};
  assign mret_target = {mepc_i[pc_size_p-1:2], 2'b00};
  assign unused_bits = ^{mtvec_i[1], mepc_i[1:0]};

  // Vectored mode only offsets interrupts; synchronous exceptions always use the base.
  always_comb begin
    trap_target = vec_base;
    if (mtvec_i[0] && mcause_q[31]) begin
      trap_target = vec_base + {25'd0, mcause_q[4:0], 2'b00};
    end
  end

  // Event qualification; the priority chain also resolves mret-vs-exception and irq-vs-mret.
  always_comb begin
    take_trap  = 1'b0;
    take_mret  = 1'b0;
    trap_cause = '0;
    if (state_q == IDLE && ex_valid_i) begin
      if (ex_illegal_i) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
      end else if (ex_ebreak_i) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_EBREAK;
      end else if (ex_ecall_i) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_ECALL;
      end else if (irq_ext_i && mie_q) begin
        take_trap  = 1'b1;
        trap_cause = CAUSE_IRQ_EXT;
      end else if (ex_mret_i) begin
        take_mret  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (take_trap) begin
          state_d = SAVE;
        end else if (take_mret) begin
          state_d = REDIR;
        end
      end
      SAVE:    state_d = REDIR;
      REDIR:   if (redir_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q    <= IDLE;
      mcause_q   <= '0;
      saved_pc_q <= '0;
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_trap) begin
        mcause_q   <= trap_cause;
        saved_pc_q <= ex_pc_ext;
        mpie_q     <= mie_q;
        mie_q      <= 1'b0;
      end else if (take_mret) begin
        mie_q      <= mpie_q;
        mpie_q     <= 1'b1;
        redir_pc_q <= mret_target;
      end else if (state_q == IDLE && mie_we_i) begin
        mie_q <= mie_wdata_i;
      end
      // Target is captured at the end of SAVE so it stays frozen for the whole handshake.
      if (state_q == SAVE) begin
        redir_pc_q <= trap_target[pc_size_p-1:0];
      end
    end
  end

  assign mepc_we_o      = (state_q == SAVE);
  assign mepc_wdata_o   = saved_pc_q;
  assign mcause_o       = mcause_q;
  assign mstatus_mie_o  = mie_q;
  assign mstatus_mpie_o = mpie_q;
  assign flush_o        = (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);
  assign redir_valid_o  = (state_q == REDIR);
  assign redir_pc_o     = redir_pc_q;

endmodule

// File: tb/tb_iot_riscv_trap_ctrl.sv
// Directed bench for iot_riscv_trap_ctrl: expected trap/return outcomes are queued
// when each event is driven and compared as the sequencer walks SAVE/REDIR/IDLE.
module tb_iot_riscv_trap_ctrl;

  localparam int unsigned PC_W = 32;

  logic            main_clk_i = 1'b0;
  logic            main_rst_i;
  logic            ex_valid_i, ex_illegal_i, ex_ebreak_i, ex_ecall_i, ex_mret_i;
  logic [PC_W-1:0] ex_pc_i;
  logic            irq_ext_i, mie_we_i, mie_wdata_i;
  logic [31:0]     mtvec_i, mepc_i;
  logic            mepc_we_o;
  logic [31:0]     mepc_wdata_o, mcause_o;
  logic            mstatus_mie_o, mstatus_mpie_o, flush_o, busy_o, redir_valid_o;
  logic [PC_W-1:0] redir_pc_o;
  logic            redir_ready_i;

  iot_riscv_trap_ctrl #(.pc_size_p(PC_W)) dut (
    .main_clk_i     (main_clk_i),
    .main_rst_i     (main_rst_i),
    .ex_valid_i     (ex_valid_i),
    .ex_pc_i        (ex_pc_i),
    .ex_illegal_i   (ex_illegal_i),
    .ex_ebreak_i    (ex_ebreak_i),
    .ex_ecall_i     (ex_ecall_i),
    .ex_mret_i      (ex_mret_i),
    .irq_ext_i      (irq_ext_i),
    .mie_we_i       (mie_we_i),
    .mie_wdata_i    (mie_wdata_i),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .mepc_we_o      (mepc_we_o),
    .mepc_wdata_o   (mepc_wdata_o),
    .mcause_o       (mcause_o),
    .mstatus_mie_o  (mstatus_mie_o),
    .mstatus_mpie_o (mstatus_mpie_o),
    .flush_o        (flush_o),
    .busy_o         (busy_o),
    .redir_valid_o  (redir_valid_o),
    .redir_pc_o     (redir_pc_o),
    .redir_ready_i  (redir_ready_i)
  );

  always #5 main_clk_i = ~main_clk_i;

  typedef struct {
    bit          trap;
    logic [31:0] cause;
    logic [31:0] mepc;
    logic [31:0] target;
    bit          mie;
    bit          mpie;
    int unsigned stall;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned fails  = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge main_clk_i);
    #1;
  endtask

  task automatic quiet;
    ex_valid_i   = 1'b0;
    ex_illegal_i = 1'b0;
    ex_ebreak_i  = 1'b0;
    ex_ecall_i   = 1'b0;
    ex_mret_i    = 1'b0;
    irq_ext_i    = 1'b0;
    mie_we_i     = 1'b0;
    mie_wdata_i  = 1'b0;
  endtask

  // Events and MIE writes while busy must be ignored, so keep them asserted then.
  task automatic noise(input logic mie_val);
    ex_valid_i   = 1'b1;
    ex_illegal_i = 1'b1;
    ex_ecall_i   = 1'b1;
    ex_mret_i    = 1'b1;
    ex_pc_i      = 32'hDEAD_0000;
    irq_ext_i    = 1'b1;
    mie_we_i     = 1'b1;
    mie_wdata_i  = mie_val;
  endtask

  task automatic push(input bit trap, input logic [31:0] cause, input logic [31:0] mepc,
                      input logic [31:0] target, input bit mie, input bit mpie,
                      input int unsigned stall);
    exp_t e;
    e.trap = trap; e.cause = cause; e.mepc = mepc; e.target = target;
    e.mie = mie; e.mpie = mpie; e.stall = stall;
    sb_q.push_back(e);
  endtask

  task automatic set_mie(input logic v);
    mie_we_i = 1'b1; mie_wdata_i = v;
    tick;
    mie_we_i = 1'b0;
    check1("mie_write", mstatus_mie_o, v);
  endtask

  // Clock the edge that takes the driven event, then follow it back to IDLE.
  task automatic fire;
    exp_t e;
    tick;
    if (sb_q.size() == 0) begin
      total++; fails++;
      $error("FAIL scoreboard observed=empty expected=entry");
      quiet;
      return;
    end
    e = sb_q.pop_front();
    noise(~e.mie);
    if (e.trap) begin
      check1 ("save_mepc_we",   mepc_we_o,      1'b1);
      check32("save_mepc_data", mepc_wdata_o,   e.mepc);
      check32("save_mcause",    mcause_o,       e.cause);
      check1 ("save_flush",     flush_o,        1'b1);
      check1 ("save_redir_vld", redir_valid_o,  1'b0);
      check1 ("save_mie",       mstatus_mie_o,  e.mie);
      check1 ("save_mpie",      mstatus_mpie_o, e.mpie);
      tick;
    end
    check1 ("redir_valid",  redir_valid_o,  1'b1);
    check32("redir_pc",     redir_pc_o,     e.target);
    check1 ("redir_mepc_we", mepc_we_o,     1'b0);
    check1 ("redir_flush",  flush_o,        1'b1);
    check1 ("redir_busy",   busy_o,         1'b1);
    check32("redir_mcause", mcause_o,       e.cause);
    check1 ("redir_mie",    mstatus_mie_o,  e.mie);
    check1 ("redir_mpie",   mstatus_mpie_o, e.mpie);
    for (int i = 0; i < int'(e.stall); i++) begin
      redir_ready_i = 1'b0;
      tick;
      check1 ("stall_valid", redir_valid_o, 1'b1);
      check32("stall_pc",    redir_pc_o,    e.target);
      check1 ("stall_flush", flush_o,       1'b1);
    end
    redir_ready_i = 1'b1;
    tick;
    redir_ready_i = 1'b0;
    quiet;
    check1 ("idle_busy",   busy_o,         1'b0);
    check1 ("idle_valid",  redir_valid_o,  1'b0);
    check1 ("idle_flush",  flush_o,        1'b0);
    check32("idle_mcause", mcause_o,       e.cause);
    check1 ("idle_mie",    mstatus_mie_o,  e.mie);
    check1 ("idle_mpie",   mstatus_mpie_o, e.mpie);
  endtask

  initial begin
    main_rst_i    = 1'b1;
    redir_ready_i = 1'b0;
    ex_pc_i       = '0;
    mtvec_i       = 32'h200;
    mepc_i        = '0;
    quiet;
    tick;
    tick;
    main_rst_i = 1'b0;
    check32("rst_mcause", mcause_o, 32'h0);
    check1 ("rst_mie",    mstatus_mie_o, 1'b0);
    check1 ("rst_mpie",   mstatus_mpie_o, 1'b0);
    check1 ("rst_busy",   busy_o, 1'b0);
    check1 ("rst_valid",  redir_valid_o, 1'b0);
    check32("rst_rpc",    redir_pc_o, 32'h0);

    // ECALL, direct vector
    set_mie(1'b1);
    ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'h100; mtvec_i = 32'h200;
    push(1'b1, 32'd11, 32'h100, 32'h200, 1'b0, 1'b1, 0);
    fire;

    // External interrupt, vectored
    set_mie(1'b1);
    ex_valid_i = 1'b1; irq_ext_i = 1'b1; ex_pc_i = 32'h400; mtvec_i = 32'h301;
    push(1'b1, 32'h8000_000B, 32'h400, 32'h32C, 1'b0, 1'b1, 0);
    fire;

    // MRET restores MIE from MPIE, aligns mepc, leaves mcause
    ex_valid_i = 1'b1; ex_mret_i = 1'b1; mepc_i = 32'h1237;
    push(1'b0, 32'h8000_000B, 32'h0, 32'h1234, 1'b1, 1'b1, 0);
    fire;

    // ECALL with vectored mtvec goes to the base
    ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'h500; mtvec_i = 32'h301;
    push(1'b1, 32'd11, 32'h500, 32'h300, 1'b0, 1'b1, 0);
    fire;

    // illegal+ecall+irq: illegal wins; redirect held 5 cycles
    set_mie(1'b1);
    ex_valid_i = 1'b1; ex_illegal_i = 1'b1; ex_ecall_i = 1'b1; irq_ext_i = 1'b1;
    ex_pc_i = 32'h600; mtvec_i = 32'h301;
    push(1'b1, 32'd2, 32'h600, 32'h300, 1'b0, 1'b1, 5);
    fire;

    // ebreak+mret: exception wins
    ex_valid_i = 1'b1; ex_ebreak_i = 1'b1; ex_mret_i = 1'b1; ex_pc_i = 32'h700; mtvec_i = 32'h200;
    push(1'b1, 32'd3, 32'h700, 32'h200, 1'b0, 1'b0, 0);
    fire;

    // irq+mret with MIE=1: irq wins
    set_mie(1'b1);
    ex_valid_i = 1'b1; irq_ext_i = 1'b1; ex_mret_i = 1'b1; ex_pc_i = 32'h800;
    push(1'b1, 32'h8000_000B, 32'h800, 32'h200, 1'b0, 1'b1, 0);
    fire;

    // Masked irq stays pending until MIE is written
    ex_valid_i = 1'b1; irq_ext_i = 1'b1; ex_pc_i = 32'h900;
    for (int i = 0; i < 3; i++) begin
      tick;
      check1("masked_busy",    busy_o,    1'b0);
      check1("masked_mepc_we", mepc_we_o, 1'b0);
    end
    mie_we_i = 1'b1; mie_wdata_i = 1'b1;
    tick;
    mie_we_i = 1'b0; mie_wdata_i = 1'b0;
    check1("unmask_busy", busy_o,        1'b0);
    check1("unmask_mie",  mstatus_mie_o, 1'b1);
    push(1'b1, 32'h8000_000B, 32'h900, 32'h200, 1'b0, 1'b1, 0);
    fire;

    // Reset while in REDIR drops the request
    set_mie(1'b1);
    ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 32'hA00;
    tick;
    quiet;
    tick;
    check1("pre_rst_valid", redir_valid_o, 1'b1);
    main_rst_i = 1'b1;
    tick;
    main_rst_i = 1'b0;
    check1 ("mid_rst_valid",  redir_valid_o,  1'b0);
    check32("mid_rst_rpc",    redir_pc_o,     32'h0);
    check1 ("mid_rst_busy",   busy_o,         1'b0);
    check1 ("mid_rst_flush",  flush_o,        1'b0);
    check1 ("mid_rst_mie",    mstatus_mie_o,  1'b0);
    check1 ("mid_rst_mpie",   mstatus_mpie_o, 1'b0);
    check32("mid_rst_mcause", mcause_o,       32'h0);
    check1 ("mid_rst_we",     mepc_we_o,      1'b0);
    check32("mid_rst_wdata",  mepc_wdata_o,   32'h0);
    tick;
    check1("post_rst_busy", busy_o, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/iot_riscv_trap_ctrl.md
# iot_riscv_trap_ctrl

Machine-mode trap and return sequencer for the iot_riscv core. Sits downstream of the CSR file: it consumes `mtvec`/`mepc` and exception/interrupt/`mret` events from EX. It then produces the `mepc` write, `mcause`, the `mstatus.MIE`/`MPIE` bits, a pipeline flush, and a handshaked PC redirect to fetch.

## Interface
- `pc_size_p`, default 32, width of PC values (≤ 32).

- `main_clk_i`  in  1  core clock.
- `main_rst_i`  in  1  reset, synchronous, active-high.
- `ex_valid_i`  in  1  valid instruction in EX this cycle.
- `ex_pc_i`  in  `pc_size_p`  PC of EX instruction.
- `ex_illegal_i`  in  1  illegal-instruction exception.
- `ex_ebreak_i`  in  1  EBREAK.
- `ex_ecall_i`  in  1  ECALL.
- `ex_mret_i`  in  1  MRET.
- `irq_ext_i`  in  1  external interrupt, level.
- `mie_we_i`  in  1  CSR write of `mstatus.MIE`.
- `mie_wdata_i`  in  1  new MIE value.
- `mtvec_i`  in  32  trap vector from CSR file.
- `mepc_i`  in  32  return PC from CSR file.
- `mepc_we_o`  out  1  `mepc` write strobe to CSR file.
- `mepc_wdata_o`  out  32  `mepc` write data.
- `mcause_o`  out  32  last trap cause.
- `mstatus_mie_o`  out  1  global interrupt enable.
- `mstatus_mpie_o`  out  1  previous MIE.
- `flush_o`  out  1  kill IF/ID/EX contents.
- `busy_o`  out  1  sequencer not IDLE.
- `redir_valid_o`  out  1  redirect request.
- `redir_pc_o`  out  `pc_size_p`  redirect target.
- `redir_ready_i`  in  1  fetch accepts redirect.

## Operation
- **States:**
  - IDLE.
  - SAVE: one cycle.
  - REDIR: hold until accepted.
- **Event qualification:** sampled only in IDLE with `ex_valid_i`=1. Priority:
  - illegal: cause 2
  - ebreak: cause 3
  - ecall: cause 11
  - interrupt: cause 0x8000_000B, only if `irq_ext_i` & MIE
  - mret
- **Trap (IDLE→SAVE):**
  - latch cause into `mcause_o`.
  - latch `ex_pc_i`, zero-extended to 32, as the saved PC.
  - MPIE←MIE, MIE←0.
- **SAVE:**
  - `mepc_we_o`=1 and `mepc_wdata_o`=saved PC.
  - Target computed: base = {`mtvec_i`[31:2],2'b00}.
  - If `mtvec_i`[0]=1 and the cause is an interrupt, target = base + 4·cause[4:0]; otherwise target = base.
  - Addition is modulo 2^32, then truncated to `pc_size_p`.
  - Next state REDIR.
- **MRET (IDLE→REDIR directly):**
  - target = `mepc_i`[pc_size_p-1:0] with bits [1:0] forced to 0.
  - MIE←MPIE, MPIE←1.
  - `mcause_o` and `mepc` unchanged.
- **REDIR:**
  - `redir_valid_o`=1; `redir_pc_o` is stable until `redir_ready_i`=1.
  - On acceptance, go to IDLE in the next cycle.
- `flush_o` = 1 in SAVE and REDIR. `busy_o` = (state≠IDLE).
- **`mie_we_i`:**
  - Applied only in IDLE when no trap/mret is taken that cycle; trap/mret updates win.
  - Ignored in SAVE/REDIR.
- All EX events outside IDLE are ignored; the flushed instructions are never re-sampled.

## Timing
- **Reset** (any state, synchronous):
  - state IDLE.
  - `mcause_o`=0, MIE=0, MPIE=0.
  - `mepc_we_o`=0, `mepc_wdata_o`=0.
  - `flush_o`=0, `busy_o`=0.
  - `redir_valid_o`=0, `redir_pc_o`=0.
- Reset mid-REDIR drops the request without waiting for ready.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- **Trap taken at edge N:**
  - SAVE in cycle N+1 (`mepc_we_o` high exactly one cycle).
  - REDIR from N+2.
  - Minimum 3 cycles IDLE→IDLE with `redir_ready_i`=1.
- **MRET taken at edge N:** REDIR in cycle N+1.
- `redir_ready_i` low for k cycles extends REDIR by k cycles; `redir_pc_o` is unchanged throughout.
- **Simultaneous events:**
  - Exception + irq: the exception wins; irq is reconsidered after return to IDLE, because it is level.
  - mret + exception: the exception wins.
  - irq + mret with MIE=1: the irq wins.

## Test plan
- Reset, then ECALL at `ex_pc_i`=0x100 with `mtvec_i`=0x200 → `mepc_we_o` pulse with data 0x100; `mcause_o`=11; redirect to 0x200; MIE 1→0, MPIE=1.
- `mtvec_i`=0x301 (vectored), MIE=1, `irq_ext_i`=1 → `mcause_o`=0x8000000B, redirect to 0x32C. Same vector with ECALL → redirect to 0x300.
- MRET with `mepc_i`=0x1237, MPIE=1 → REDIR next cycle at 0x1234; MIE=1, MPIE=1; no `mepc_we_o`.
- Illegal+ecall+irq in the same cycle → cause 2. Hold `redir_ready_i`=0 for 5 cycles → `redir_valid_o`/`redir_pc_o` stable, `flush_o` high throughout.
- MIE=0, `irq_ext_i`=1 → no trap. Then `mie_we_i`=1/data 1 → trap starts the cycle after MIE sets.
- Assert `main_rst_i` during REDIR → next cycle all outputs 0, state IDLE, MIE=0.
